bp_btb_2bit: RTL and testbench



---
 rtl/bp_pkg.sv | 20 ++
 rtl/bp_sat_counter.sv | 22 ++
 rtl/bp_btb_2bit.sv | 94 +++++++++
 tb/tb_bp_btb_2bit.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared constants and helpers for the 2-bit branch target buffer
package bp_pkg;

  localparam logic [1:0] STRONG_NT = 2'b00;
  localparam logic [1:0] WEAK_NT   = 2'b01;
  localparam logic [1:0] WEAK_T    = 2'b10;
  localparam logic [1:0] STRONG_T  = 2'b11;

  localparam int INST_BYTES = 4;

  function automatic int calc_idx_w(input int entries);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < entries) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// rtl/bp_sat_counter.sv - 2-bit saturating predictor next-state and prediction bit
module bp_sat_counter
  import bp_pkg::*;
(
  input  logic [1:0] state,
  input  logic       taken,
  output logic [1:0] next_state,
  output logic       pred
);

  always_comb begin
    next_state = state;
    if (taken) begin
      if (state != STRONG_T) next_state = state + 2'd1;
    end else begin
      if (state != STRONG_NT) next_state = state - 2'd1;
    end
  end

  assign pred = state[1];

endmodule

// File: rtl/bp_btb_2bit.sv
// rtl/bp_btb_2bit.sv - direct-mapped BTB with 2-bit predictors, flush and mispredict counter
module bp_btb_2bit
  import bp_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 32,
  parameter int TAG_W   = 8,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  lookup_pc,
  output logic             lookup_hit,
  output logic             pred_taken,
  output logic [XLEN-1:0]  pred_target,
  input  logic             upd_valid,
  input  logic [XLEN-1:0]  upd_pc,
  input  logic             upd_taken,
  input  logic [XLEN-1:0]  upd_target,
  input  logic             upd_mispredict,
  input  logic             flush,
  output logic [CNT_W-1:0] mispred_count
);

  localparam int IDX_W = calc_idx_w(ENTRIES);

  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [XLEN-1:0]   target_q [ENTRIES];
  logic [1:0]        ctr_q    [ENTRIES];
  logic [CNT_W-1:0]  mis_q, mis_d;

  logic [IDX_W-1:0]  lk_idx, up_idx;
  logic [TAG_W-1:0]  lk_tag, up_tag;
  logic              up_hit;
  logic [1:0]        up_ctr_next;
  logic              up_pred;

  // Index and tag are taken by shifting the whole PC so that bits [1:0] drop out naturally.
  assign lk_idx = IDX_W'(lookup_pc >> 2);
  assign lk_tag = TAG_W'(lookup_pc >> (IDX_W + 2));
  assign up_idx = IDX_W'(upd_pc >> 2);
  assign up_tag = TAG_W'(upd_pc >> (IDX_W + 2));

  assign lookup_hit  = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred_taken  = lookup_hit && ctr_q[lk_idx][1];
  assign pred_target = lookup_hit ? target_q[lk_idx] : lookup_pc + XLEN'(INST_BYTES);

  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  bp_sat_counter u_sat (
    .state      (ctr_q[up_idx]),
    .taken      (upd_taken),
    .next_state (up_ctr_next),
    .pred       (up_pred)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= STRONG_NT;
      end
    end else if (flush) begin
      // Flush drops any concurrent update; only valid bits are cleared.
      for (int i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
    end else if (upd_valid) begin
      if (up_hit) begin
        ctr_q[up_idx] <= up_ctr_next;
        if (upd_taken) target_q[up_idx] <= upd_target;
      end else if (upd_taken) begin
        valid_q[up_idx]  <= 1'b1;
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= upd_target;
        ctr_q[up_idx]    <= WEAK_T;
      end
    end
  end

  always_comb begin
    mis_d = mis_q;
    if (upd_valid && upd_mispredict && (mis_q != {CNT_W{1'b1}})) mis_d = mis_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mis_q <= '0;
    else     mis_q <= mis_d;
  end

  assign mispred_count = mis_q;

endmodule

// File: tb/tb_bp_btb_2bit.sv
// tb/tb_bp_btb_2bit.sv - self-checking bench for bp_btb_2bit with a behavioural table model
module tb_bp_btb_2bit;

  localparam int XLEN    = 32;
  localparam int ENTRIES = 32;
  localparam int TAG_W   = 8;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic [XLEN-1:0]  lookup_pc;
  logic             lookup_hit;
  logic             pred_taken;
  logic [XLEN-1:0]  pred_target;
  logic             upd_valid;
  logic [XLEN-1:0]  upd_pc;
  logic             upd_taken;
  logic [XLEN-1:0]  upd_target;
  logic             upd_mispredict;
  logic             flush;
  logic [CNT_W-1:0] mispred_count;

  int checks = 0;
  int errors = 0;

  bp_btb_2bit #(.XLEN(XLEN), .ENTRIES(ENTRIES), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .lookup_pc      (lookup_pc),
    .lookup_hit     (lookup_hit),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .upd_mispredict (upd_mispredict),
    .flush          (flush),
    .mispred_count  (mispred_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: table of entries with an integer confidence level 0..3.
  bit          m_valid  [ENTRIES];
  int          m_tag    [ENTRIES];
  logic [31:0] m_target [ENTRIES];
  int          m_level  [ENTRIES];
  int          m_mis;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic int tag_of(input logic [31:0] pc);
    return int'((pc / (4 * ENTRIES)) % (1 << TAG_W));
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        m_valid[i] = 0; m_tag[i] = 0; m_target[i] = 0; m_level[i] = 0;
      end
      m_mis = 0;
    end else begin
      if (upd_valid && upd_mispredict && m_mis < CNT_MAX) m_mis = m_mis + 1;
      if (flush) begin
        for (int i = 0; i < ENTRIES; i++) m_valid[i] = 0;
      end else if (upd_valid) begin
        if (m_hit(upd_pc)) begin
          if (upd_taken) begin
            m_level[idx_of(upd_pc)] = (m_level[idx_of(upd_pc)] < 3) ? m_level[idx_of(upd_pc)] + 1 : 3;
            m_target[idx_of(upd_pc)] = upd_target;
          end else begin
            m_level[idx_of(upd_pc)] = (m_level[idx_of(upd_pc)] > 0) ? m_level[idx_of(upd_pc)] - 1 : 0;
          end
        end else if (upd_taken) begin
          m_valid[idx_of(upd_pc)]  = 1;
          m_tag[idx_of(upd_pc)]    = tag_of(upd_pc);
          m_target[idx_of(upd_pc)] = upd_target;
          m_level[idx_of(upd_pc)]  = 2;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("model_hit", {31'd0, lookup_hit}, {31'd0, m_hit(lookup_pc)});
      chk("model_taken", {31'd0, pred_taken}, {31'd0, m_hit(lookup_pc) && (m_level[idx_of(lookup_pc)] >= 2)});
      chk("model_target", pred_target, m_hit(lookup_pc) ? m_target[idx_of(lookup_pc)] : lookup_pc + 32'd4);
      chk("model_count", 32'(mispred_count), 32'(m_mis));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt, input logic mis);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = taken; upd_target = tgt; upd_mispredict = mis;
    step();
    upd_valid = 1'b0; upd_mispredict = 1'b0;
  endtask

  task automatic look(input string name, input logic [31:0] pc, input logic hit, input logic tk, input logic [31:0] tgt);
    lookup_pc = pc;
    #1;
    chk({name, "_hit"}, {31'd0, lookup_hit}, {31'd0, hit});
    chk({name, "_taken"}, {31'd0, pred_taken}, {31'd0, tk});
    chk({name, "_target"}, pred_target, tgt);
  endtask

  initial begin
    rst = 1'b0; lookup_pc = 32'h100; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
    upd_target = '0; upd_mispredict = 1'b0; flush = 1'b0;
    #1 rst = 1'b1;
    look("reset", 32'h100, 1'b0, 1'b0, 32'h104);
    chk("reset_count", 32'(mispred_count), 32'd0);
    step(); step();
    rst = 1'b0;
    step();

    upd(32'h100, 1'b1, 32'h200, 1'b0);
    look("alloc", 32'h100, 1'b1, 1'b1, 32'h200);
    upd(32'h100, 1'b0, 32'h999, 1'b0);
    look("weak_nt", 32'h100, 1'b1, 1'b0, 32'h200);
    upd(32'h100, 1'b0, 32'h0, 1'b0);
    upd(32'h100, 1'b0, 32'h0, 1'b0);
    look("strong_nt", 32'h100, 1'b1, 1'b0, 32'h200);
    upd(32'h100, 1'b1, 32'h200, 1'b0);
    look("no_underflow", 32'h100, 1'b1, 1'b0, 32'h200);

    for (int i = 0; i < 4; i++) upd(32'h100, 1'b1, 32'h200, 1'b0);
    upd(32'h100, 1'b0, 32'h0, 1'b0);
    look("sat_then_nt", 32'h100, 1'b1, 1'b1, 32'h200);
    upd(32'h100, 1'b0, 32'h0, 1'b0);
    look("sat_two_nt", 32'h100, 1'b1, 1'b0, 32'h200);

    upd(32'h180, 1'b1, 32'h400, 1'b0);
    look("alias_old", 32'h100, 1'b0, 1'b0, 32'h104);
    look("alias_new", 32'h180, 1'b1, 1'b1, 32'h400);
    upd(32'h300, 1'b0, 32'h0, 1'b0);
    look("nt_no_alloc", 32'h300, 1'b0, 1'b0, 32'h304);
    look("pc_low_bits", 32'h183, 1'b1, 1'b1, 32'h400);

    lookup_pc = 32'h180;
    upd_valid = 1'b1; upd_pc = 32'h180; upd_taken = 1'b1; upd_target = 32'h500;
    look("same_cycle_pre", 32'h180, 1'b1, 1'b1, 32'h400);
    @(posedge clk); #1;
    upd_valid = 1'b0;
    look("same_cycle_post", 32'h180, 1'b1, 1'b1, 32'h500);

    look("wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);

    upd(32'h104, 1'b1, 32'h600, 1'b0);
    look("second_entry", 32'h104, 1'b1, 1'b1, 32'h600);
    flush = 1'b1;
    upd(32'h208, 1'b1, 32'h700, 1'b1);
    flush = 1'b0;
    look("flush_a", 32'h180, 1'b0, 1'b0, 32'h184);
    look("flush_b", 32'h104, 1'b0, 1'b0, 32'h108);
    look("flush_upd_dropped", 32'h208, 1'b0, 1'b0, 32'h20C);
    chk("flush_count", 32'(mispred_count), 32'd1);

    upd_mispredict = 1'b1;
    step();
    upd_mispredict = 1'b0;
    chk("unqualified_mis", 32'(mispred_count), 32'd1);
    for (int i = 0; i < (1 << CNT_W) + 3; i++) upd(32'h180, 1'b1, 32'h700, 1'b1);
    chk("count_saturated", 32'(mispred_count), 32'h0000_000F);
    look("realloc", 32'h180, 1'b1, 1'b1, 32'h700);

    rst = 1'b1;
    look("mid_reset", 32'h180, 1'b0, 1'b0, 32'h184);
    chk("mid_reset_count", 32'(mispred_count), 32'd0);
    #1 rst = 1'b0;
    step();
    upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1; upd_target = 32'h800;
    rst = 1'b1;
    step();
    upd_valid = 1'b0;
    rst = 1'b0;
    look("inflight_lost", 32'h100, 1'b0, 1'b0, 32'h104);
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
